// File: rtl/nl_traffic_sink_pkg.sv
// Shared types for the NoC traffic sink: flit layout, error codes and FSM states.
// Latency statistics are enabled in the top by defining NL_TRAFFIC_SINK_LATENCY_EN.
package nl_traffic_sink_pkg;

    localparam int NUM_SRC   = 16;
    localparam int SRC_W     = 4;
    localparam int SEQ_W     = 8;
    localparam int IDX_W     = 4;
    localparam int TS_W      = 16;
    localparam int PAYLOAD_W = 32;

    typedef struct packed {
        logic                 head;
        logic                 tail;
        logic [SRC_W-1:0]     src;
        logic [SEQ_W-1:0]     pkt_seq;
        logic [IDX_W-1:0]     flit_idx;
        logic [TS_W-1:0]      ts;
        logic [PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef enum logic [2:0] {
        ERR_NONE,
        ERR_OVERFLOW,
        ERR_NO_HEAD,
        ERR_NO_TAIL,
        ERR_SRC,
        ERR_ORDER,
        ERR_SEQ
    } sink_err_t;

    typedef enum logic {
        ST_IDLE,
        ST_IN_PKT
    } sink_state_t;

endpackage

// File: rtl/nl_traffic_sink_buffer.sv
// Input FIFO of the traffic sink: one-hot ring read/write pointers plus an occupancy counter.
module nl_traffic_sink_buffer
    import nl_traffic_sink_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  flit_t            wdata_i,
    output flit_t            rdata_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [OCC_W-1:0] occ_o
);

    flit_t            mem_q [DEPTH];
    logic [DEPTH-1:0] wr_ptr_q;
    logic [DEPTH-1:0] rd_ptr_q;
    logic [OCC_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= DEPTH'(1);
            rd_ptr_q <= DEPTH'(1);
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= {wr_ptr_q[DEPTH-2:0], wr_ptr_q[DEPTH-1]};
            if (pop_i)  rd_ptr_q <= {rd_ptr_q[DEPTH-2:0], rd_ptr_q[DEPTH-1]};
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (push_i && wr_ptr_q[i]) mem_q[i] <= wdata_i;
        end
    end

    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_ptr_q[i]) rdata_o = mem_q[i];
        end
    end

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == OCC_W'(DEPTH));
    assign occ_o   = count_q;

endmodule

// File: rtl/nl_traffic_sink.sv
// NoC traffic sink: credit-controlled flit buffer, packet framing/order/sequence checker and stats.
// Define NL_TRAFFIC_SINK_LATENCY_EN to build the timestamp counter and the lat_sum/lat_max logic.
module nl_traffic_sink
    import nl_traffic_sink_pkg::*;
#(
    parameter int BUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flit_valid,
    input  flit_t            flit_in,
    input  logic             sink_stall,
    output logic             credit_out,
    output logic             pkt_done,
    output logic [SRC_W-1:0] pkt_src,
    output logic [31:0]      flit_count,
    output logic [31:0]      pkt_count,
    output logic [15:0]      err_count,
    output logic             err_flag,
    output sink_err_t        err_code,
    output logic [47:0]      lat_sum,
    output logic [TS_W-1:0]  lat_max
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);

    flit_t            rd_flit;
    logic             buf_empty, buf_full;
    logic [OCC_W-1:0] buf_occ;
    logic             pop, push, overflow;

    assign pop      = !buf_empty && !sink_stall;
    assign push     = flit_valid && (!buf_full || pop);
    assign overflow = flit_valid && !push;

    nl_traffic_sink_buffer #(.DEPTH(BUF_DEPTH)) u_buffer (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (flit_in),
        .rdata_o (rd_flit),
        .empty_o (buf_empty),
        .full_o  (buf_full),
        .occ_o   (buf_occ)
    );

    sink_state_t      state_q, state_d;
    logic [SRC_W-1:0] cur_src_q, cur_src_d;
    logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
    logic             pkt_err_q, pkt_err_d;
    logic [SEQ_W-1:0] exp_seq_q [NUM_SRC];
    sink_err_t        pop_err;
    logic             seq_wr, complete, complete_clean;
    logic             seq_bad, src_bad, idx_bad;

    always_comb begin
        state_d        = state_q;
        cur_src_d      = cur_src_q;
        exp_idx_d      = exp_idx_q;
        pkt_err_d      = pkt_err_q;
        pop_err        = ERR_NONE;
        seq_wr         = 1'b0;
        complete       = 1'b0;
        complete_clean = 1'b0;
        seq_bad        = (rd_flit.pkt_seq != exp_seq_q[rd_flit.src]);
        src_bad        = (rd_flit.src != cur_src_q);
        idx_bad        = (rd_flit.flit_idx != exp_idx_q);
        if (pop) begin
            if (rd_flit.head) begin
                // A head always starts a new packet, abandoning any open one.
                if (state_q == ST_IN_PKT) pop_err = ERR_NO_TAIL;
                else if (seq_bad)         pop_err = ERR_SEQ;
                seq_wr    = 1'b1;
                cur_src_d = rd_flit.src;
                exp_idx_d = IDX_W'(1);
                pkt_err_d = seq_bad;
                if (rd_flit.tail) begin
                    complete       = 1'b1;
                    complete_clean = !seq_bad;
                    state_d        = ST_IDLE;
                end else begin
                    state_d = ST_IN_PKT;
                end
            end else if (state_q == ST_IDLE) begin
                pop_err = ERR_NO_HEAD;
            end else begin
                if (src_bad)      pop_err = ERR_SRC;
                else if (idx_bad) pop_err = ERR_ORDER;
                exp_idx_d = exp_idx_q + 1'b1;
                pkt_err_d = pkt_err_q | src_bad | idx_bad;
                if (rd_flit.tail) begin
                    complete       = 1'b1;
                    complete_clean = !(pkt_err_q | src_bad | idx_bad);
                    state_d        = ST_IDLE;
                end
            end
        end
    end

    logic             pop_err_any;
    logic [16:0]      err_sum;
    sink_err_t        err_code_d;
    logic             credit_q, done_q, err_flag_q;
    logic [SRC_W-1:0] src_q;
    logic [31:0]      flit_count_q, pkt_count_q;
    logic [15:0]      err_count_q;
    sink_err_t        err_code_q;

    assign pop_err_any = (pop_err != ERR_NONE);
    assign err_sum     = {1'b0, err_count_q} + 17'(overflow) + 17'(pop_err_any);
    assign err_code_d  = overflow ? ERR_OVERFLOW : (pop_err_any ? pop_err : err_code_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cur_src_q    <= '0;
            exp_idx_q    <= '0;
            pkt_err_q    <= 1'b0;
            for (int i = 0; i < NUM_SRC; i++) exp_seq_q[i] <= '0;
            credit_q     <= 1'b0;
            done_q       <= 1'b0;
            src_q        <= '0;
            flit_count_q <= '0;
            pkt_count_q  <= '0;
            err_count_q  <= '0;
            err_flag_q   <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            cur_src_q  <= cur_src_d;
            exp_idx_q  <= exp_idx_d;
            pkt_err_q  <= pkt_err_d;
            if (seq_wr) exp_seq_q[rd_flit.src] <= rd_flit.pkt_seq + SEQ_W'(1);
            credit_q   <= pop;
            done_q     <= complete;
            if (complete) src_q <= cur_src_d;
            if (pop && flit_count_q != '1)     flit_count_q <= flit_count_q + 1'b1;
            if (complete && pkt_count_q != '1) pkt_count_q  <= pkt_count_q + 1'b1;
            err_count_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
            if (overflow || pop_err_any) err_flag_q <= 1'b1;
            err_code_q <= err_code_d;
        end
    end

`ifdef NL_TRAFFIC_SINK_LATENCY_EN
    logic [TS_W-1:0] ts_now_q, head_ts_q, lat_max_q, lat;
    logic [47:0]     lat_sum_q;
    logic [48:0]     lat_acc;

    // A single-flit packet takes its head timestamp straight from the popped flit.
    assign lat     = ts_now_q - (rd_flit.head ? rd_flit.ts : head_ts_q);
    assign lat_acc = {1'b0, lat_sum_q} + 49'(lat);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ts_now_q  <= '0;
            head_ts_q <= '0;
            lat_sum_q <= '0;
            lat_max_q <= '0;
        end else begin
            ts_now_q <= ts_now_q + 1'b1;
            if (pop && rd_flit.head) head_ts_q <= rd_flit.ts;
            if (complete_clean) begin
                lat_sum_q <= lat_acc[48] ? '1 : lat_acc[47:0];
                if (lat > lat_max_q) lat_max_q <= lat;
            end
        end
    end

    assign lat_sum = lat_sum_q;
    assign lat_max = lat_max_q;
`else
    assign lat_sum = '0;
    assign lat_max = '0;
`endif

    logic unused_bits;
    assign unused_bits = ^{rd_flit.payload, rd_flit.ts, buf_occ, complete_clean};

    assign credit_out = credit_q;
    assign pkt_done   = done_q;
    assign pkt_src    = src_q;
    assign flit_count = flit_count_q;
    assign pkt_count  = pkt_count_q;
    assign err_count  = err_count_q;
    assign err_flag   = err_flag_q;
    assign err_code   = err_code_q;

endmodule
